sr_round: RTL

Stochastic-rounding back end for the half-precision arithmetic units (multiplier and siblings). It consumes a truncated result word, its class flags and the round-mantissa field. It then rounds the result up with probability equal to the discarded fraction, using an internal Galois LFSR. The block is a two-stage valid/ready pipeline placed directly after the combinational arithmetic core; it re-derives the output class flags when rounding carries into the exponent.

---
 rtl/sr_round.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sr_round.sv
// Stochastic-rounding back end: two-stage valid/ready pipeline that rounds a truncated
// half-precision result up with probability equal to its discarded fraction.
module sr_round #(
    parameter int num_bits       = 16,
    parameter int exp_width      = 5,
    parameter int mant_width     = 10,
    parameter int num_round_bits = 8,
    parameter int lfsr_width     = 16,
    parameter logic [lfsr_width-1:0] lfsr_taps  = 16'hB400,
    parameter logic [lfsr_width-1:0] lfsr_reset = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [num_bits-1:0]                in_result,
    input  logic [mant_width+num_round_bits-1:0] in_round_mant,
    input  logic                               in_zero,
    input  logic                               in_inf,
    input  logic                               in_subN,
    input  logic                               in_Norm,
    input  logic                               in_QNan,
    input  logic                               in_SNan,
    input  logic                               seed_load,
    input  logic [lfsr_width-1:0]              seed,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [num_bits-1:0]                out_result,
    output logic                               out_zero,
    output logic                               out_inf,
    output logic                               out_subN,
    output logic                               out_Norm,
    output logic                               out_QNan,
    output logic                               out_SNan
);

    logic [lfsr_width-1:0]     lfsr;
    logic                      s1_valid, s2_valid;
    logic [num_bits-1:0]       s1_result;
    logic [num_round_bits-1:0] s1_r, s1_rand;
    logic                      s1_zero, s1_inf, s1_subn, s1_norm, s1_qnan, s1_snan;
    logic                      accept, s2_load, s1_move;

    // Upper round-mantissa bits carry the kept mantissa, already present in in_result.
    logic unused_mant;
    assign unused_mant = ^in_round_mant[mant_width+num_round_bits-1:num_round_bits];

    assign s2_load  = !s2_valid || out_ready;
    assign s1_move  = s1_valid && s2_load;
    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= lfsr_reset;
        end else if (seed_load) begin
            lfsr <= (seed == '0) ? lfsr_width'(1) : seed;
        end else if (accept) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? lfsr_taps : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
            s1_r      <= '0;
            s1_rand   <= '0;
            s1_zero   <= 1'b0;
            s1_inf    <= 1'b0;
            s1_subn   <= 1'b0;
            s1_norm   <= 1'b0;
            s1_qnan   <= 1'b0;
            s1_snan   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_result <= in_result;
                s1_r      <= in_round_mant[num_round_bits-1:0];
                s1_rand   <= lfsr[num_round_bits-1:0];
                s1_zero   <= in_zero;
                s1_inf    <= in_inf;
                s1_subn   <= in_subN;
                s1_norm   <= in_Norm;
                s1_qnan   <= in_QNan;
                s1_snan   <= in_SNan;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 rounding and reclassification.
    logic [num_round_bits:0]   rsum;
    logic                      carry;
    logic [num_bits-2:0]       inc;
    logic [exp_width-1:0]      inc_exp;
    logic [num_bits-1:0]       nx_result;
    logic                      nx_zero, nx_inf, nx_subn, nx_norm, nx_qnan, nx_snan;

    assign rsum    = {1'b0, s1_r} + {1'b0, s1_rand};
    assign carry   = rsum[num_round_bits];
    assign inc     = s1_result[num_bits-2:0] + {{(num_bits-2){1'b0}}, carry};
    assign inc_exp = inc[mant_width +: exp_width];

    always_comb begin
        nx_result = s1_result;
        nx_zero   = s1_zero;
        nx_inf    = s1_inf;
        nx_subn   = s1_subn;
        nx_norm   = s1_norm;
        nx_qnan   = s1_qnan;
        nx_snan   = s1_snan;
        if (s1_norm || s1_subn) begin
            nx_result = {s1_result[num_bits-1], inc};
            if (s1_norm && (&inc_exp)) begin
                nx_inf  = 1'b1;
                nx_norm = 1'b0;
                nx_result[mant_width-1:0] = '0;
            end else if (s1_subn && inc_exp == exp_width'(1)) begin
                nx_norm = 1'b1;
                nx_subn = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_inf    <= 1'b0;
            out_subN   <= 1'b0;
            out_Norm   <= 1'b0;
            out_QNan   <= 1'b0;
            out_SNan   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= nx_result;
                out_zero   <= nx_zero;
                out_inf    <= nx_inf;
                out_subN   <= nx_subn;
                out_Norm   <= nx_norm;
                out_QNan   <= nx_qnan;
                out_SNan   <= nx_snan;
            end
        end
    end

endmodule
